tdc_hw_accum: RTL

TDC_HW_ACCUM -- requirements
Module: tdc_hw_accum

---
 rtl/tdc_hw_accum.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: accumulates the Hamming weight of 2^LOG2_SAMPLES delay-line
// tap words into one measurement. It reports the sum, the truncated mean and,
// optionally, the min/max sample weight.
// Optional feature: define TDC_HW_ACCUM_MINMAX_EN to build min/max tracking.
// Without it, min_hw and max_hw are tied to zero.
//
// Handshake: res_valid rises one cycle after the last sample is taken. It is
// held with stable results until a cycle where res_valid & res_ready are both
// high; that cycle completes the transfer. res_valid may not drop before then.
module tdc_hw_accum #(
    parameter int TAPS         = 127,
    parameter int LOG2_SAMPLES = 4,
    localparam int HW_W        = $clog2(TAPS + 1),
    localparam int ACC_W       = HW_W + LOG2_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TAPS-1:0]  taps_in,
    input  logic             taps_valid,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] sum,
    output logic [HW_W-1:0]  mean,
    output logic [HW_W-1:0]  min_hw,
    output logic [HW_W-1:0]  max_hw,
    output logic             drop,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << LOG2_SAMPLES) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_W-1:0]  sum_q;
    logic              drop_q;
    logic [HW_W-1:0]   hw;
    logic              clear, take, accept, drop_set;

    function automatic logic [HW_W-1:0] popcount(input logic [TAPS-1:0] v);
        logic [HW_W-1:0] c;
        c = '0;
        for (int i = 0; i < TAPS; i++) c = c + HW_W'(v[i]);
        return c;
    endfunction

    // Combinational Hamming weight of the incoming word
    always_comb hw = popcount(taps_in);

    // Next-state logic and per-cycle datapath controls
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        take     = 1'b0;
        accept   = 1'b0;
        drop_set = taps_valid && (state_q != ACCUM);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    clear   = 1'b1;
                end
            end
            ACCUM: begin
                take = taps_valid;
                if (taps_valid && cnt_q == LAST) state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    accept = 1'b1;
                    if (start) begin
                        state_d = ACCUM;
                        clear   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Sum, sample counter and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (clear) begin
                sum_q <= '0;
                cnt_q <= '0;
            end else if (take) begin
                sum_q <= sum_q + ACC_W'(hw);
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Accepting a result clears drop even if a stray sample lands
            // in the same cycle; that sample belongs to the closed result.
            if (accept)        drop_q <= 1'b0;
            else if (drop_set) drop_q <= 1'b1;
        end
    end

`ifdef TDC_HW_ACCUM_MINMAX_EN
    logic [HW_W-1:0] min_q, max_q;

    // Min/max tracking: min starts at all-ones, max at zero, on each clear
    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else if (clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (take) begin
            if (hw < min_q) min_q <= hw;
            if (hw > max_q) max_q <= hw;
        end
    end

    assign min_hw = min_q;
    assign max_hw = max_q;
`else
    assign min_hw = '0;
    assign max_hw = '0;
`endif

    assign busy      = (state_q == ACCUM);
    assign res_valid = (state_q == HOLD);
    assign sum       = sum_q;
    assign mean      = HW_W'(sum_q >> LOG2_SAMPLES);
    assign drop      = drop_q;
    assign dbg_state = state_q;

endmodule
